compressor_sequencer: RTL

COMPRESSOR_SEQUENCER -- requirements
Module: compressor_sequencer

---
 rtl/compressor_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/compressor_sequencer.sv
//=============================================================================
// Module   : compressor_sequencer
// Purpose  : Loads ROWS row words, then streams them MSB first, one bit per
//            row per cycle, into an external shift-register harness that
//            feeds a combinational compressor. After SETTLE further cycles
//            the compressor output is captured and offered on a
//            valid/ready result port.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            ld_valid/ready  - row beat handshake, ld_data = row word
//            src_bit[ROWS]   - registered serial bits into the harness
//            dst_bus[OUT_W]  - compressor outputs from the harness
//            res_valid/ready - result handshake, res_data = captured result
//            busy            - high whenever the block is not in LOAD
//            job_count[16]   - saturating count of consumed results
//                              (present only with COMPSEQ_PERF_EN)
// Config   : define COMPSEQ_PERF_EN to add the job_count output.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module compressor_sequencer #(
  parameter int ROWS   = 31,
  parameter int WIDTH  = 31,
  parameter int OUT_W  = 36,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  output logic [ROWS-1:0]  src_bit,
  input  logic [OUT_W-1:0] dst_bus,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
`ifdef COMPSEQ_PERF_EN
  output logic [15:0]      job_count,
`endif
  output logic             busy
);

  localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = 4;  // SETTLE is at most 15

  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
  localparam logic [KW-1:0] K_TOP  = KW'(WIDTH - 2);
  localparam logic [WW-1:0] W_LAST = WW'(SETTLE - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [RW-1:0]     r, r_d;
  logic [KW-1:0]     k, k_d;
  logic [WW-1:0]     w, w_d;
  logic [ROWS-1:0]   src_d;
  logic              res_valid_d;
  logic              capture;
  logic              ld_fire;
  logic [KW-1:0]     sel;

  // Row storage is never reset: every job rewrites all ROWS entries.
  logic [WIDTH-1:0]  row_mem [ROWS];

  assign ld_ready = (state == LOAD);
  assign busy     = (state != LOAD);
  assign ld_fire  = ld_valid && (state == LOAD);

  // src_bit is registered, so the bit for SHIFT cycle k+1 is selected while
  // in cycle k. Cycle 0's bit is chosen on the final load beat, when the last
  // row is still on ld_data rather than in storage.
  assign sel = K_TOP - k;

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      row_mem[r] <= ld_data;
    end
  end

  always_comb begin
    state_d     = state;
    r_d         = r;
    k_d         = k;
    w_d         = w;
    src_d       = '0;
    res_valid_d = res_valid;
    capture     = 1'b0;

    case (state)
      LOAD: begin
        if (ld_valid) begin
          if (r == R_LAST) begin
            state_d = SHIFT;
            r_d     = '0;
            k_d     = '0;
            for (int i = 0; i < ROWS - 1; i++) begin
              src_d[i] = row_mem[i][WIDTH-1];
            end
            src_d[ROWS-1] = ld_data[WIDTH-1];
          end else begin
            r_d = r + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (k == K_LAST) begin
          state_d = WAIT;
          k_d     = '0;
          w_d     = '0;
        end else begin
          k_d = k + 1'b1;
          for (int i = 0; i < ROWS; i++) begin
            src_d[i] = row_mem[i][sel];
          end
        end
      end
      WAIT: begin
        if (w == W_LAST) begin
          state_d     = DONE;
          capture     = 1'b1;
          res_valid_d = 1'b1;
        end else begin
          w_d = w + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = LOAD;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      r         <= '0;
      k         <= '0;
      w         <= '0;
      src_bit   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_d;
      r         <= r_d;
      k         <= k_d;
      w         <= w_d;
      src_bit   <= src_d;
      res_valid <= res_valid_d;
      if (capture) begin
        res_data <= dst_bus;
      end
    end
  end

`ifdef COMPSEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_count <= '0;
    end else if (res_valid && res_ready && (job_count != 16'hFFFF)) begin
      job_count <= job_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
